// File: rtl/volume_ctrl_if.sv
// Button-level inputs and volume status outputs of the volume controller.
// The slave side is the controller; the master side drives the buttons.
interface volume_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             up;
    logic             down;
    logic             mute_btn;
    logic [WIDTH-1:0] level;
    logic             muted;
    logic [WIDTH-1:0] out_level;
    logic             step_up;
    logic             step_dn;

    modport master (
        output up, down, mute_btn,
        input  level, muted, out_level, step_up, step_dn
    );

    modport slave (
        input  up, down, mute_btn,
        output level, muted, out_level, step_up, step_dn
    );
endinterface

// File: rtl/volume_ctrl.sv
// Saturating volume level controller with single-step press, hold/auto-repeat,
// up/down conflict blocking and a toggle mute that any step attempt cancels.
module volume_ctrl #(
    parameter int WIDTH         = 4,
    parameter int MAX_LEVEL     = 15,
    parameter int RESET_LEVEL   = 8,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input logic          clk,
    input logic          n_reset,
    volume_ctrl_if.slave bus
);
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC);

    localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]    REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [WIDTH-1:0] LVL_MAX   = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0] LVL_RST   = WIDTH'(RESET_LEVEL);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_BLOCKED} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;      // 1 = up, 0 = down
    logic [WIDTH-1:0] level_q, level_d;
    logic             muted_q, muted_d;
    logic             mute_prev_q;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;

    logic step;
    logic latched;
    logic opposite;
    logic mute_rise;

    assign latched   = dir_q ? bus.up   : bus.down;
    assign opposite  = dir_q ? bus.down : bus.up;
    assign mute_rise = bus.mute_btn & ~mute_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.up ^ bus.down) begin
                    step    = 1'b1;
                    dir_d   = bus.up;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (bus.up && bus.down) begin
                    state_d = S_BLOCKED;
                end
            end
            S_HOLD: begin
                // Release outranks a conflict, which outranks counter expiry.
                if (!latched) begin
                    state_d = S_IDLE;
                end else if (opposite) begin
                    state_d = S_BLOCKED;
                end else if (cnt_q == HOLD_LAST) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPEAT: begin
                if (!latched) begin
                    state_d = S_IDLE;
                end else if (opposite) begin
                    state_d = S_BLOCKED;
                end else if (cnt_q == REP_LAST) begin
                    step  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BLOCKED: begin
                if (!bus.up && !bus.down) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d   = level_q;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
        muted_d   = muted_q ^ mute_rise;
        if (step) begin
            // Any step attempt unmutes, even a saturated one.
            muted_d = 1'b0;
            if (dir_d) begin
                if (level_q < LVL_MAX) begin
                    level_d   = level_q + 1'b1;
                    step_up_d = 1'b1;
                end
            end else if (level_q != '0) begin
                level_d   = level_q - 1'b1;
                step_dn_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            level_q     <= LVL_RST;
            muted_q     <= 1'b0;
            mute_prev_q <= 1'b0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            level_q     <= level_d;
            muted_q     <= muted_d;
            mute_prev_q <= bus.mute_btn;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.muted     = muted_q;
    assign bus.out_level = muted_q ? '0 : level_q;
    assign bus.step_up   = step_up_q;
    assign bus.step_dn   = step_dn_q;
endmodule

// File: tb/tb_volume_ctrl.sv
// Bench for volume_ctrl: directed vector table, hold/saturation/reset sequences,
// then random button activity checked against a press-age reference model.
module tb_volume_ctrl;
    localparam int W = 4;
    localparam int MAXL = 15;
    localparam int RSTL = 8;
    localparam int H = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    volume_ctrl_if #(.WIDTH(W)) vif ();

    volume_ctrl #(
        .WIDTH(W), .MAX_LEVEL(MAXL), .RESET_LEVEL(RSTL),
        .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .bus(vif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a held button is characterised only by its age in edges.
    int m_level, m_mode, m_age;   // mode: 0 idle, 1 held, 2 blocked
    bit m_dir, m_muted, m_mprev, m_su, m_sd;

    task automatic model_step(input bit r, input bit u, input bit d, input bit m);
        bit attempt;
        bit lat, opp;
        attempt = 1'b0;
        if (!r) begin
            m_level = RSTL; m_muted = 0; m_mprev = 0; m_su = 0; m_sd = 0;
            m_mode = 0; m_age = 0;
            return;
        end
        case (m_mode)
            2: if (!u && !d) m_mode = 0;
            1: begin
                lat = m_dir ? u : d;
                opp = m_dir ? d : u;
                if (!lat) m_mode = 0;
                else if (opp) m_mode = 2;
                else begin
                    m_age++;
                    if (m_age == H || (m_age > H && (m_age - H) % R == 0)) attempt = 1;
                end
            end
            default: begin
                if (u ^ d) begin
                    m_mode = 1; m_dir = u; m_age = 0; attempt = 1;
                end else if (u && d) m_mode = 2;
            end
        endcase
        m_su = 0; m_sd = 0;
        if (m && !m_mprev) m_muted = !m_muted;
        if (attempt) begin
            m_muted = 0;
            if (m_dir && m_level < MAXL) begin m_level++; m_su = 1; end
            else if (!m_dir && m_level > 0) begin m_level--; m_sd = 1; end
        end
        m_mprev = m;
    endtask

    task automatic apply(input bit r, input bit u, input bit d, input bit m);
        n_reset = r; vif.up = u; vif.down = d; vif.mute_btn = m;
        @(posedge clk);
        model_step(r, u, d, m);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int lvl, input int mtd, input int su, input int sd);
        chk({tag, ".level"}, int'(vif.level), lvl);
        chk({tag, ".muted"}, int'(vif.muted), mtd);
        chk({tag, ".out_level"}, int'(vif.out_level), mtd ? 0 : lvl);
        chk({tag, ".step_up"}, int'(vif.step_up), su);
        chk({tag, ".step_dn"}, int'(vif.step_dn), sd);
    endtask

    typedef struct {
        bit rst, up, dn, mute;
        int lvl;
        bit mtd, su, sd;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int pulses;
        bit ru, rd, rm, rr;

        tbl[0]  = '{0, 0, 0, 0, 8, 0, 0, 0};   // reset
        tbl[1]  = '{0, 0, 0, 0, 8, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 9, 0, 1, 0};   // single up tap
        tbl[3]  = '{1, 0, 0, 0, 9, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 8, 0, 0, 1};   // down held 3 edges
        tbl[5]  = '{1, 0, 1, 0, 8, 0, 0, 0};
        tbl[6]  = '{1, 0, 1, 0, 8, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 8, 0, 0, 0};
        tbl[8]  = '{1, 1, 1, 0, 8, 0, 0, 0};   // both pressed: blocked
        tbl[9]  = '{1, 0, 1, 0, 8, 0, 0, 0};   // still blocked
        tbl[10] = '{1, 0, 0, 0, 8, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 7, 0, 0, 1};   // fresh press after unblock
        tbl[12] = '{1, 0, 0, 0, 7, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 1, 7, 1, 0, 0};   // mute rising edge
        tbl[14] = '{1, 0, 0, 1, 7, 1, 0, 0};   // held mute: no toggle
        tbl[15] = '{1, 1, 0, 0, 8, 0, 1, 0};   // step unmutes
        tbl[16] = '{1, 0, 0, 0, 8, 0, 0, 0};

        vif.up = 0; vif.down = 0; vif.mute_btn = 0;
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].rst, tbl[i].up, tbl[i].dn, tbl[i].mute);
            chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].mtd, tbl[i].su, tbl[i].sd);
        end

        // Auto-repeat from 8: steps at edges 0, 8, 12, 16
        for (int i = 0; i < 20; i++) begin
            apply(1, 1, 0, 0);
            chk($sformatf("rep%0d.step_up", i), int'(vif.step_up),
                (i == 0 || i == 8 || i == 12 || i == 16) ? 1 : 0);
        end
        chk("rep.level", int'(vif.level), 12);
        apply(1, 0, 0, 0);
        chk("rep_rel.step_up", int'(vif.step_up), 0);
        chk("rep_rel.level", int'(vif.level), 12);

        // Up saturation from 14
        for (int i = 0; i < 2; i++) begin apply(1, 1, 0, 0); apply(1, 0, 0, 0); end
        chk("pre_sat.level", int'(vif.level), 14);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin apply(1, 1, 0, 0); pulses += int'(vif.step_up); end
        chk("sat_up.pulses", pulses, 1);
        chk("sat_up.level", int'(vif.level), 15);
        apply(1, 0, 0, 0);

        // Down saturation from 1
        for (int i = 0; i < 14; i++) begin apply(1, 0, 1, 0); apply(1, 0, 0, 0); end
        chk("pre_satdn.level", int'(vif.level), 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin apply(1, 0, 1, 0); pulses += int'(vif.step_dn); end
        chk("sat_dn.pulses", pulses, 1);
        chk("sat_dn.level", int'(vif.level), 0);
        apply(1, 0, 0, 0);

        // Reset during REPEAT with up still held
        for (int i = 0; i < 14; i++) apply(1, 1, 0, 0);
        chk("midrep.level", int'(vif.level), 3);
        apply(0, 1, 0, 0);
        chk_all("midrst", 8, 0, 0, 0);
        apply(1, 1, 0, 0);
        chk_all("postrst", 9, 0, 1, 0);
        for (int i = 1; i < H; i++) begin
            apply(1, 1, 0, 0);
            chk($sformatf("postrst_hold%0d.level", i), int'(vif.level), 9);
        end
        apply(1, 1, 0, 0);
        chk_all("postrst_second", 10, 0, 1, 0);
        apply(1, 0, 0, 0);

        // Random phase against the reference model
        apply(0, 0, 0, 0);
        ru = 0; rd = 0; rm = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) ru = !ru;
            if ($urandom_range(0, 9) == 0) rd = !rd;
            if ($urandom_range(0, 15) == 0) rm = !rm;
            rr = ($urandom_range(0, 299) != 0);
            apply(rr, ru, rd, rm);
            chk_all($sformatf("rnd%0d", i), m_level, int'(m_muted), int'(m_su), int'(m_sd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/volume_ctrl.md
# volume_ctrl

Volume level controller for the front-panel audio path. It takes the debounced `up`, `down` and `mute_btn` button levels and turns them into a saturating volume level. A single press gives one step; holding a button gives auto-repeat steps. The block also handles mute, and it sits between the button synchronisers and the output attenuator that consumes `out_level`.

## Interface

Parameters:
- `WIDTH`, default 4: width of the level register.
- `MAX_LEVEL`, default 15: upper saturation bound. Must be ≤ 2^WIDTH−1.
- `RESET_LEVEL`, default 8: level loaded on reset. Must be ≤ MAX_LEVEL.
- `HOLD_CYCLES`, default 8: cycles a button must stay held after the first step before auto-repeat starts. Must be ≥ 2.
- `REPEAT_CYCLES`, default 4: cycles between auto-repeat steps. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `n_reset`, input, 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `up`, input, 1: volume-up button level. Already synchronised and debounced.
- `down`, input, 1: volume-down button level. Already synchronised and debounced.
- `mute_btn`, input, 1: mute button level. Each rising edge toggles mute.
- `level`, output, WIDTH: current stored level. Registered.
- `muted`, output, 1: mute flag. Registered.
- `out_level`, output, WIDTH: `muted ? 0 : level`. Combinational from registers.
- `step_up`, output, 1: one-cycle pulse when `level` has just incremented. Registered.
- `step_dn`, output, 1: one-cycle pulse when `level` has just decremented. Registered.

## Operation

States:
- **IDLE**: no button is being serviced.
  - `up` xor `down` sampled high → apply a step in that direction, latch the direction, clear the counter, go to HOLD.
  - Both sampled high → no step, go to BLOCKED.
- **HOLD**: counter increments each cycle while the latched button stays high.
  - When the counter reaches HOLD_CYCLES−1 and the button is still high → step, clear the counter, go to REPEAT.
- **REPEAT**: counter increments each cycle.
  - When the counter reaches REPEAT_CYCLES−1 → step, clear the counter, stay in REPEAT.
- **BLOCKED**: no steps. Go to IDLE at the first edge where `up` and `down` are both low.

Exits from HOLD and REPEAT:
- Latched button sampled low → IDLE, with no step on that edge. This takes priority over counter expiry.
- Opposite button sampled high while the latched button is still high → BLOCKED, with no step.

Step rules:
- Up step: `level <= level+1`, saturating at MAX_LEVEL.
- Down step: `level <= level−1`, saturating at 0.
- `step_up`/`step_dn` pulse only if `level` actually changed. A saturated step gives no pulse, and the FSM sequence is unchanged.
- A step attempted while `muted`=1 clears `muted` on the same edge. This applies even if the step saturates.

Mute:
- The block keeps `mute_prev`, a registered copy of `mute_btn`.
- A rising edge (`mute_btn`=1 and `mute_prev`=0) toggles `muted`.
- If a mute rising edge and a step attempt land on the same edge, the step wins: `muted`=0.

Reset (`n_reset`=0 at an edge), from any state:
- FSM goes to IDLE and the counter is cleared.
- `level`=RESET_LEVEL, `muted`=0, `mute_prev`=0, `step_up`=`step_dn`=0.
- A button still held when reset is released is treated as a new press at the first edge with `n_reset`=1.

## Timing

- Press latency: `up` high at edge N from IDLE → `level` updated after edge N, and `step_up` high for the cycle N..N+1.
- A continuously held button produces steps at edges N, N+HOLD_CYCLES, then N+HOLD_CYCLES+k·REPEAT_CYCLES for k ≥ 1.
- Release latency: button low at edge M → state is IDLE after M. A new press is accepted at M+1 at the earliest.
- Mute latency: `mute_btn` rising sampled at edge N → `muted` and `out_level` change after N.
- Counter width: `$clog2(max(HOLD_CYCLES, REPEAT_CYCLES))` bits.

## Test plan

- **Reset values**: hold `n_reset`=0 for 2 edges → `level`=8, `muted`=0, `out_level`=8, `step_up`=`step_dn`=0.
- **Single tap**: `up` high for 1 edge → `level`=9, one `step_up` pulse; `down` high for 3 edges → `level`=8, one `step_dn` pulse.
- **Auto-repeat**: from 8, `up` high for 20 consecutive edges (0..19) → steps at edges 0, 8, 12, 16 and final `level`=12. Release at edge 20 → no further steps.
- **Saturation**: from 14, hold `up` for 20 edges → `level`=15 with exactly one `step_up` pulse. From 1, hold `down` → `level`=0 with one `step_dn` pulse.
- **Conflict and mute**:
  - From IDLE, raise `up` and `down` on the same edge → no step. Drop `up` only → still no step. Drop both, then raise `down` → one step.
  - `mute_btn` 0→1 → `muted`=1, `out_level`=0, `level` unchanged.
  - While muted, tap `up` → `muted`=0 and `level`+1.
- **Reset mid-operation**: assert `n_reset`=0 during REPEAT while `up` is still held → `level`=8. With `up` still high at the first edge after reset release → one immediate step to 9, then the next step HOLD_CYCLES edges later.
